ulpi_rx_decoder: RTL and testbench

- Receive-side front end of the ULPI link. Sits directly downstream of the PHY pins, alongside the register-write/chirp FSM in top.
- Tracks DIR/NXT bus ownership and turnaround, and splits PHY-driven cycles into RX CMD updates and USB packet bytes.
- Publishes registered LineState/VBUS/RxEvent status, a debounced LineState, and a framed packet byte stream (SOP/EOP/error/length) for the link FSM and the future packet parser.

---
 rtl/ulpi_pkg.sv | 33 +++
 rtl/ulpi_rx_decoder_if.sv | 35 +++
 rtl/ulpi_linestate_filter.sv | 64 ++++++
 rtl/ulpi_rx_decoder.sv | 171 +++++++++++++++++
 tb/tb_ulpi_rx_decoder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI receive path.
// Holds the LineState and RxEvent codes, RX CMD bit-field positions, the
// framing FSM state encoding and a small RxEvent extraction helper.
package ulpi_pkg;

  typedef enum logic [1:0] {
    LsSe0 = 2'b00,
    LsJ   = 2'b01,
    LsK   = 2'b10,
    LsSe1 = 2'b11
  } linestate_e;

  typedef enum logic [1:0] {
    EvNone       = 2'b00,
    EvRxActive   = 2'b01,
    EvHostDiscon = 2'b10,
    EvRxError    = 2'b11
  } rx_event_e;

  // RX CMD byte layout: [1:0] LineState, [3:2] VBUS state, [5:4] RxEvent.
  localparam int unsigned RxCmdLsLsb   = 0;
  localparam int unsigned RxCmdVbusLsb = 2;
  localparam int unsigned RxCmdEvLsb   = 4;

  // Packet framing FSM encoding.
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  function automatic rx_event_e rxcmd_event(input logic [7:0] cmd);
    return rx_event_e'(cmd[RxCmdEvLsb +: 2]);
  endfunction

endpackage

// File: rtl/ulpi_rx_decoder_if.sv
// Bundle of the PHY-facing inputs and the decoded status / packet stream.
// Modports:
//   master - PHY/stimulus side: drives USB_DIR/USB_NXT/USB_DATA_IN, observes outputs.
//   slave  - decoder side: consumes the ULPI pins, drives status and RX stream.
interface ulpi_rx_decoder_if #(
  parameter int unsigned LEN_W = 10
);
  logic             USB_DIR;
  logic             USB_NXT;
  logic [7:0]       USB_DATA_IN;
  logic [1:0]       LINESTATE;
  logic [1:0]       VBUS_STATE;
  logic             LS_CHANGE;
  logic             LS_STABLE;
  logic             RX_ACTIVE;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             RX_SOP;
  logic             RX_EOP;
  logic             RX_ERR;
  logic [LEN_W-1:0] RX_LEN;
  logic             BUS_OWNED;

  modport master (
    output USB_DIR, USB_NXT, USB_DATA_IN,
    input  LINESTATE, VBUS_STATE, LS_CHANGE, LS_STABLE, RX_ACTIVE, RX_DATA,
           RX_VALID, RX_SOP, RX_EOP, RX_ERR, RX_LEN, BUS_OWNED
  );

  modport slave (
    input  USB_DIR, USB_NXT, USB_DATA_IN,
    output LINESTATE, VBUS_STATE, LS_CHANGE, LS_STABLE, RX_ACTIVE, RX_DATA,
           RX_VALID, RX_SOP, RX_EOP, RX_ERR, RX_LEN, BUS_OWNED
  );
endinterface

// File: rtl/ulpi_linestate_filter.sv
// LineState register with change detection and debounce.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   ls_update_i    - ls_i carries a fresh LineState sample this cycle
//   ls_i           - candidate LineState
//   ls_o           - registered LineState
//   ls_change_o    - one-cycle pulse coincident with ls_o taking a new value
//   ls_stable_o    - ls_o unchanged for at least STABLE_CYCLES cycles
module ulpi_linestate_filter
  import ulpi_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ls_update_i,
  input  logic [1:0] ls_i,
  output logic [1:0] ls_o,
  output logic       ls_change_o,
  output logic       ls_stable_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [1:0]      ls_q, ls_d;
  logic            change_q, change_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    ls_d     = ls_q;
    change_d = 1'b0;
    cnt_d    = cnt_q;
    if (ls_update_i && (ls_i != ls_q)) begin
      ls_d     = ls_i;
      change_d = 1'b1;
      cnt_d    = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Evaluated on the next count so stable drops together with the change pulse.
    stable_d = (cnt_d == CntMax);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ls_q     <= LsSe0;
      change_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ls_q     <= ls_d;
      change_q <= change_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ls_o        = ls_q;
  assign ls_change_o = change_q;
  assign ls_stable_o = stable_q;

endmodule

// File: rtl/ulpi_rx_decoder.sv
// ULPI receive-side decoder.
// Tracks DIR ownership/turnaround, splits PHY-driven cycles into RX CMD
// updates and packet bytes, and frames packets (SOP/EOP/ERR/length).
// Ports:
//   CLK, RST - 60 MHz ULPI clock, synchronous active-high reset
//   bus      - slave modport: ULPI pins in, LineState/VBUS status, debounced
//              LineState, framed RX byte stream and BUS_OWNED out
module ulpi_rx_decoder
  import ulpi_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 25,
  parameter int unsigned LEN_W         = 10
) (
  input logic           CLK,
  input logic           RST,
  ulpi_rx_decoder_if.slave bus
);

  localparam logic [LEN_W-1:0] LenMax = {LEN_W{1'b1}};

  // Pins are captured first; dir_q is the capture one cycle older, so the
  // pair (usb_dir_q, dir_q) spots turnarounds one stage behind the pins.
  logic             usb_dir_q, usb_dir_d;
  logic             usb_nxt_q, usb_nxt_d;
  logic [7:0]       usb_data_q, usb_data_d;
  logic             dir_q, dir_d;

  logic [0:0]       state_q, state_d;
  logic             first_q, first_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rx_len_q, rx_len_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_sop_q, rx_sop_d;
  logic             rx_eop_q, rx_eop_d;
  logic             rx_err_q, rx_err_d;
  logic [1:0]       vbus_q, vbus_d;
  logic             bus_owned_q, bus_owned_d;

  logic      turnaround, owned, is_rxcmd, is_byte;
  rx_event_e rx_event;

  assign turnaround = (usb_dir_q != dir_q);
  assign owned      = usb_dir_q & dir_q;
  assign is_rxcmd   = owned & ~usb_nxt_q;
  assign is_byte    = owned & usb_nxt_q;
  assign rx_event   = rxcmd_event(usb_data_q);

  always_comb begin
    usb_dir_d   = bus.USB_DIR;
    usb_nxt_d   = bus.USB_NXT;
    usb_data_d  = bus.USB_DATA_IN;
    dir_d       = usb_dir_q;

    state_d     = state_q;
    first_d     = first_q;
    len_d       = len_q;
    rx_len_d    = rx_len_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sop_d    = 1'b0;
    rx_eop_d    = 1'b0;
    rx_err_d    = 1'b0;
    vbus_d      = vbus_q;
    bus_owned_d = owned;

    if (is_rxcmd) begin
      vbus_d = usb_data_q[RxCmdVbusLsb +: 2];
    end

    if (is_byte) begin
      rx_data_d  = usb_data_q;
      rx_valid_d = 1'b1;
      // A byte seen while idle opens a packet on its own.
      rx_sop_d   = (state_q == StIdle) | first_q;
      first_d    = 1'b0;
      state_d    = StActive;
      if (state_q == StIdle) begin
        len_d = LEN_W'(1);
      end else if (len_q != LenMax) begin
        len_d = len_q + LEN_W'(1);
      end
    end else if (is_rxcmd) begin
      if (state_q == StIdle) begin
        if (rx_event == EvRxActive) begin
          state_d = StActive;
          len_d   = '0;
          first_d = 1'b1;
        end
      end else begin
        unique case (rx_event)
          EvNone, EvHostDiscon, EvRxError: begin
            state_d  = StIdle;
            first_d  = 1'b0;
            rx_eop_d = 1'b1;
            rx_err_d = (rx_event == EvRxError);
            rx_len_d = len_q;
          end
          EvRxActive: ;
          default: ;
        endcase
      end
    end else if (turnaround && !usb_dir_q && (state_q == StActive)) begin
      // Link took the bus back mid-packet: truncated.
      state_d  = StIdle;
      first_d  = 1'b0;
      rx_eop_d = 1'b1;
      rx_err_d = 1'b1;
      rx_len_d = len_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      usb_dir_q   <= 1'b1;
      usb_nxt_q   <= 1'b0;
      usb_data_q  <= 8'h00;
      dir_q       <= 1'b1;
      state_q     <= StIdle;
      first_q     <= 1'b0;
      len_q       <= '0;
      rx_len_q    <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_sop_q    <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      vbus_q      <= 2'b00;
      bus_owned_q <= 1'b0;
    end else begin
      usb_dir_q   <= usb_dir_d;
      usb_nxt_q   <= usb_nxt_d;
      usb_data_q  <= usb_data_d;
      dir_q       <= dir_d;
      state_q     <= state_d;
      first_q     <= first_d;
      len_q       <= len_d;
      rx_len_q    <= rx_len_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sop_q    <= rx_sop_d;
      rx_eop_q    <= rx_eop_d;
      rx_err_q    <= rx_err_d;
      vbus_q      <= vbus_d;
      bus_owned_q <= bus_owned_d;
    end
  end

  ulpi_linestate_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_ls_filter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ls_update_i(is_rxcmd),
    .ls_i       (usb_data_q[RxCmdLsLsb +: 2]),
    .ls_o       (bus.LINESTATE),
    .ls_change_o(bus.LS_CHANGE),
    .ls_stable_o(bus.LS_STABLE)
  );

  assign bus.VBUS_STATE = vbus_q;
  assign bus.RX_ACTIVE  = (state_q == StActive);
  assign bus.RX_DATA    = rx_data_q;
  assign bus.RX_VALID   = rx_valid_q;
  assign bus.RX_SOP     = rx_sop_q;
  assign bus.RX_EOP     = rx_eop_q;
  assign bus.RX_ERR     = rx_err_q;
  assign bus.RX_LEN     = rx_len_q;
  assign bus.BUS_OWNED  = bus_owned_q;

endmodule

// File: tb/tb_ulpi_rx_decoder.sv
// Self-checking bench for ulpi_rx_decoder: directed scenarios followed by
// random pin traffic, all checked every cycle against a behavioural model.
module tb_ulpi_rx_decoder;

  localparam int unsigned StableCycles = 25;
  localparam int unsigned LenW         = 10;
  localparam int          LenMax       = (1 << LenW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ulpi_rx_decoder_if #(.LEN_W(LenW)) rx_if ();

  ulpi_rx_decoder #(
    .STABLE_CYCLES(StableCycles),
    .LEN_W        (LenW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(rx_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Pin values reach the decode one edge after they are
  // captured, so the previous capture (h_*) and the one before (h_prev_dir)
  // are what a cycle is classified on.
  bit       h_dir, h_prev_dir, h_nxt;
  bit [7:0] h_data;
  bit [1:0] m_ls, m_vbus;
  bit       m_lschg, m_stable, m_active, m_first;
  bit       m_valid, m_sop, m_eop, m_err, m_owned;
  bit [7:0] m_data;
  int       m_scnt, m_len, m_rxlen;

  task automatic model_reset();
    h_dir = 1; h_prev_dir = 1; h_nxt = 0; h_data = 0;
    m_ls = 0; m_vbus = 0; m_lschg = 0; m_stable = 0; m_active = 0; m_first = 0;
    m_valid = 0; m_sop = 0; m_eop = 0; m_err = 0; m_owned = 0; m_data = 0;
    m_scnt = 0; m_len = 0; m_rxlen = 0;
  endtask

  task automatic model_finish_pkt(input bit err);
    m_eop = 1; m_err = err; m_rxlen = m_len; m_active = 0; m_first = 0;
  endtask

  task automatic model_step(input bit d, input bit n, input bit [7:0] data);
    bit [1:0] ev;
    m_valid = 0; m_sop = 0; m_eop = 0; m_err = 0; m_lschg = 0;
    m_owned = h_dir && h_prev_dir;
    ev = h_data[5:4];
    if (m_owned && !h_nxt) begin
      m_lschg = (h_data[1:0] != m_ls);
      m_ls    = h_data[1:0];
      m_vbus  = h_data[3:2];
      if (m_active) begin
        if (ev == 2'b00 || ev == 2'b10) model_finish_pkt(0);
        else if (ev == 2'b11) model_finish_pkt(1);
      end else if (ev == 2'b01) begin
        m_active = 1; m_len = 0; m_first = 1;
      end
    end else if (m_owned && h_nxt) begin
      if (!m_active) begin
        m_active = 1; m_len = 0; m_first = 1;
      end
      m_data  = h_data;
      m_valid = 1;
      m_sop   = m_first;
      m_first = 0;
      if (m_len < LenMax) m_len++;
    end else if (!h_dir && h_prev_dir && m_active) begin
      model_finish_pkt(1);
    end
    if (m_lschg) m_scnt = 0;
    else if (m_scnt < StableCycles) m_scnt++;
    m_stable = (m_scnt == StableCycles);
    h_prev_dir = h_dir; h_dir = d; h_nxt = n; h_data = data;
  endtask

  task automatic compare_all();
    check_eq("linestate",  rx_if.LINESTATE,  m_ls);
    check_eq("vbus",       rx_if.VBUS_STATE, m_vbus);
    check_eq("ls_change",  rx_if.LS_CHANGE,  m_lschg);
    check_eq("ls_stable",  rx_if.LS_STABLE,  m_stable);
    check_eq("rx_active",  rx_if.RX_ACTIVE,  m_active);
    check_eq("rx_data",    rx_if.RX_DATA,    m_data);
    check_eq("rx_valid",   rx_if.RX_VALID,   m_valid);
    check_eq("rx_sop",     rx_if.RX_SOP,     m_valid & m_sop);
    check_eq("rx_eop",     rx_if.RX_EOP,     m_eop);
    check_eq("rx_err",     rx_if.RX_ERR,     m_err);
    check_eq("rx_len",     rx_if.RX_LEN,     m_rxlen);
    check_eq("bus_owned",  rx_if.BUS_OWNED,  m_owned);
  endtask

  // Drive one cycle of pins, let the edge happen, then compare on the falling edge.
  task automatic tick(input bit r, input bit d, input bit n, input bit [7:0] data);
    RST = r;
    rx_if.USB_DIR = d;
    rx_if.USB_NXT = n;
    rx_if.USB_DATA_IN = data;
    @(posedge CLK);
    if (r) model_reset();
    else model_step(d, n, data);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic rxcmd(input bit [7:0] cmd, input int count);
    for (int i = 0; i < count; i++) tick(0, 1, 0, cmd);
  endtask

  bit r_dir = 1;

  initial begin
    model_reset();
    rx_if.USB_DIR = 1; rx_if.USB_NXT = 0; rx_if.USB_DATA_IN = 0;

    // Reset with the PHY owning the bus, then a first SE0 RX CMD.
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 8'h00);
    check_eq("rst_owned", rx_if.BUS_OWNED, 1'b0);
    rxcmd(8'h00, 3);
    check_eq("first_ls", rx_if.LINESTATE, 2'b00);

    // Link-owned, then DIR rises with K on DATA (turnaround), then K RX CMDs.
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(0, 1, 0, 8'h56);
    rxcmd(8'h56, 28);
    check_eq("ls_k", rx_if.LINESTATE, 2'b10);
    check_eq("ls_k_stable", rx_if.LS_STABLE, 1'b1);

    // J/K alternation every 10 cycles: never stable.
    for (int s = 0; s < 4; s++) begin
      rxcmd(8'h55, 10);
      rxcmd(8'h56, 10);
    end
    check_eq("alt_stable", rx_if.LS_STABLE, 1'b0);

    // Good 3-byte packet.
    rxcmd(8'h10, 1);
    tick(0, 1, 1, 8'hC3);
    tick(0, 1, 1, 8'h01);
    tick(0, 1, 1, 8'h02);
    rxcmd(8'h00, 3);
    check_eq("len3", rx_if.RX_LEN, 3);

    // 2-byte packet ended by RxError.
    rxcmd(8'h10, 1);
    tick(0, 1, 1, 8'h11);
    tick(0, 1, 1, 8'h22);
    rxcmd(8'h30, 3);
    check_eq("len2", rx_if.RX_LEN, 2);

    // 1-byte packet truncated by DIR falling.
    rxcmd(8'h10, 1);
    tick(0, 1, 1, 8'h33);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    check_eq("len_trunc", rx_if.RX_LEN, 1);

    // Zero-length packet.
    tick(0, 1, 0, 8'h10);
    rxcmd(8'h10, 1);
    rxcmd(8'h00, 3);
    check_eq("len0", rx_if.RX_LEN, 0);

    // NXT on the DIR-rising turnaround: byte dropped.
    tick(0, 0, 0, 8'h00);
    tick(0, 1, 1, 8'hAA);
    rxcmd(8'h00, 2);

    // Reset mid-packet: no EOP.
    rxcmd(8'h10, 1);
    tick(0, 1, 1, 8'h44);
    tick(1, 1, 0, 8'h00);
    check_eq("rst_mid_eop", rx_if.RX_EOP, 1'b0);
    rxcmd(8'h00, 3);

    // Long packet: length counter saturates.
    rxcmd(8'h10, 1);
    for (int i = 0; i < LenMax + 8; i++) tick(0, 1, 1, 8'(i));
    rxcmd(8'h00, 3);
    check_eq("len_sat", rx_if.RX_LEN, LenMax);

    // Random pin traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) r_dir = ~r_dir;
      tick(($urandom_range(199) == 0), r_dir, 1'($urandom_range(1)), 8'($urandom_range(255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
